// File: rtl/ps_conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : ps_conv3x3_stream
// Brief    : Streaming 3x3 filter stage (passthrough / Gaussian / Gaussian +
//            threshold) with FWFT FIFO read control, two line buffers and
//            downstream backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module ps_conv3x3_stream #(
    parameter int DW     = 8,
    parameter int LINE_W = 640
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic [1:0]    i_mode,
    input  logic [DW-1:0] i_thresh,
    input  logic [DW-1:0] i_data,
    input  logic          i_empty,
    output logic          o_rd,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready
);

    localparam int                 c_COL_W       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [c_COL_W-1:0] c_COL_LAST    = c_COL_W'(LINE_W - 1);
    localparam logic [1:0]         c_MODE_PASS   = 2'b00;
    localparam logic [1:0]         c_MODE_GAUSS  = 2'b01;

    // One Gaussian row: a + 2b + c, wide enough for 4*(2^DW-1)
    function automatic logic [DW+1:0] row_sum(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [DW-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Pipeline control
    logic          w_en;
    logic          w_pop;
    logic [1:0]    w_mode_in;

    // Registered state and next-state
    logic [1:0]         r_mode_q,      w_mode_d;
    logic [c_COL_W-1:0] r_col_q,       w_col_d;
    logic [1:0]         r_row_q,       w_row_d;
    logic               r_s1_valid_q,  w_s1_valid_d;
    logic               r_s2_valid_q,  w_s2_valid_d;
    logic               r_o_valid_q,   w_o_valid_d;
    logic [DW-1:0]      r_o_data_q,    w_o_data_d;

    // Datapath registers (no reset needed; validity is carried by the valids)
    logic [DW-1:0]      r_win_q [3][3];
    logic [DW-1:0]      w_win_d [3][3];
    logic [DW-1:0]      r_s1_pix_q,    w_s1_pix_d;
    logic [DW-1:0]      r_s2_pix_q,    w_s2_pix_d;
    logic [DW+1:0]      r_s2_sum_q [3];
    logic [DW+1:0]      w_s2_sum_d [3];

    // Line buffers: lb0 holds the previous row, lb1 the row before that
    logic [DW-1:0]      r_lb0_mem [LINE_W];
    logic [DW-1:0]      r_lb1_mem [LINE_W];
    logic [DW-1:0]      w_lb0_rd;
    logic [DW-1:0]      w_lb1_rd;

    logic [DW+3:0]      w_sum;
    logic [DW-1:0]      w_gauss;

    assign w_en      = !(r_o_valid_q && !i_ready);
    assign w_pop     = w_en && !i_empty && !i_rst && !i_flush;
    assign w_mode_in = (i_mode == 2'b11) ? c_MODE_PASS : i_mode;
    assign w_lb0_rd  = r_lb0_mem[r_col_q];
    assign w_lb1_rd  = r_lb1_mem[r_col_q];

    // Final 3x3 sum with rounding; (16*max + 8) >> 4 never exceeds DW bits
    assign w_sum   = {2'b00, r_s2_sum_q[0]} + {1'b0, r_s2_sum_q[1], 1'b0}
                   + {2'b00, r_s2_sum_q[2]} + (DW+4)'(8);
    assign w_gauss = DW'(w_sum >> 4);

    // Next-state logic for all pipeline stages; flush wins over stall and pop
    always_comb begin
        w_mode_d     = r_mode_q;
        w_col_d      = r_col_q;
        w_row_d      = r_row_q;
        w_win_d      = r_win_q;
        w_s1_valid_d = r_s1_valid_q;
        w_s1_pix_d   = r_s1_pix_q;
        w_s2_valid_d = r_s2_valid_q;
        w_s2_pix_d   = r_s2_pix_q;
        w_s2_sum_d   = r_s2_sum_q;
        w_o_valid_d  = r_o_valid_q;
        w_o_data_d   = r_o_data_q;

        if (w_en) begin
            // S1: position counters, window shift, window-valid decision
            w_s1_valid_d = 1'b0;
            if (w_pop) begin
                w_col_d = (r_col_q == c_COL_LAST) ? '0 : r_col_q + 1'b1;
                if (r_col_q == c_COL_LAST && r_row_q != 2'd2)
                    w_row_d = r_row_q + 2'd1;
                for (int r = 0; r < 3; r++) begin
                    w_win_d[r][0] = r_win_q[r][1];
                    w_win_d[r][1] = r_win_q[r][2];
                end
                w_win_d[0][2] = w_lb1_rd;
                w_win_d[1][2] = w_lb0_rd;
                w_win_d[2][2] = i_data;
                w_s1_pix_d    = i_data;
                w_s1_valid_d  = (r_mode_q == c_MODE_PASS) ||
                                (r_row_q == 2'd2 && int'(r_col_q) >= 2);
            end
            // S2: per-row partial sums
            w_s2_valid_d = r_s1_valid_q;
            w_s2_pix_d   = r_s1_pix_q;
            for (int r = 0; r < 3; r++)
                w_s2_sum_d[r] = row_sum(r_win_q[r][0], r_win_q[r][1], r_win_q[r][2]);
            // S3: normalise / threshold into the output register
            w_o_valid_d = r_s2_valid_q;
            if (r_s2_valid_q) begin
                if (r_mode_q == c_MODE_PASS)
                    w_o_data_d = r_s2_pix_q;
                else if (r_mode_q == c_MODE_GAUSS)
                    w_o_data_d = w_gauss;
                else
                    w_o_data_d = (w_gauss >= i_thresh) ? '1 : '0;
            end
        end

        if (i_flush) begin
            w_mode_d     = w_mode_in;
            w_col_d      = '0;
            w_row_d      = '0;
            w_s1_valid_d = 1'b0;
            w_s2_valid_d = 1'b0;
            w_o_valid_d  = 1'b0;
            w_o_data_d   = '0;
        end
    end

    // Control registers with synchronous reset; reset relatches the mode
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode_q     <= w_mode_in;
            r_col_q      <= '0;
            r_row_q      <= '0;
            r_s1_valid_q <= 1'b0;
            r_s2_valid_q <= 1'b0;
            r_o_valid_q  <= 1'b0;
            r_o_data_q   <= '0;
        end else begin
            r_mode_q     <= w_mode_d;
            r_col_q      <= w_col_d;
            r_row_q      <= w_row_d;
            r_s1_valid_q <= w_s1_valid_d;
            r_s2_valid_q <= w_s2_valid_d;
            r_o_valid_q  <= w_o_valid_d;
            r_o_data_q   <= w_o_data_d;
        end
    end

    // Datapath registers follow their next-state values every cycle
    always_ff @(posedge i_clk) begin
        r_win_q    <= w_win_d;
        r_s1_pix_q <= w_s1_pix_d;
        r_s2_pix_q <= w_s2_pix_d;
        r_s2_sum_q <= w_s2_sum_d;
    end

    // Line buffer update on every pop; contents survive reset and flush
    always_ff @(posedge i_clk) begin
        if (w_pop) begin
            r_lb1_mem[r_col_q] <= w_lb0_rd;
            r_lb0_mem[r_col_q] <= i_data;
        end
    end

    assign o_rd    = w_pop;
    assign o_data  = r_o_data_q;
    assign o_valid = r_o_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_ps_conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps_conv3x3_stream
// Brief    : Directed self-checking bench for ps_conv3x3_stream (DW=8,
//            LINE_W=4) with a behavioural FWFT FIFO in front of the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps_conv3x3_stream;

    localparam int DW     = 8;
    localparam int LINE_W = 4;

    logic          clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_flush = 1'b0;
    logic [1:0]    i_mode = 2'b00;
    logic [DW-1:0] i_thresh = '0;
    logic [DW-1:0] i_data = '0;
    logic          i_empty = 1'b1;
    logic          o_rd;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [DW-1:0] fifo[$];
    logic [DW-1:0] out_q[$];
    int            out_c[$];
    int            pop_c[$];

    ps_conv3x3_stream #(.DW(DW), .LINE_W(LINE_W)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_flush  (i_flush),
        .i_mode   (i_mode),
        .i_thresh (i_thresh),
        .i_data   (i_data),
        .i_empty  (i_empty),
        .o_rd     (o_rd),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present FIFO head to the DUT and let combinational outputs settle
    task automatic drive();
        i_empty = (fifo.size() == 0);
        i_data  = (fifo.size() == 0) ? '0 : fifo[0];
        #1;
    endtask

    // Log handshakes and pops, then advance one clock
    task automatic edge_step();
        logic rd;
        rd = o_rd;
        if (o_valid === 1'b1 && i_ready) begin
            out_q.push_back(o_data);
            out_c.push_back(cyc);
        end
        if (rd === 1'b1) pop_c.push_back(cyc);
        @(posedge clk);
        if (rd === 1'b1) void'(fifo.pop_front());
        @(negedge clk);
        cyc++;
    endtask

    task automatic step();
        drive();
        edge_step();
    endtask

    task automatic clear_logs();
        out_q.delete();
        out_c.delete();
        pop_c.delete();
    endtask

    task automatic do_reset(input logic [1:0] mode);
        i_rst  = 1'b1;
        i_mode = mode;
        drive();
        check("rst_rd", {31'd0, o_rd}, 32'd0);
        edge_step();
        step();
        i_rst = 1'b0;
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_data", {24'd0, o_data}, 32'd0);
        clear_logs();
    endtask

    task automatic check_outs(input string tag, input logic [DW-1:0] exp[4]);
        check({tag, "_count"}, out_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < out_q.size()) check({tag, "_data"}, {24'd0, out_q[i]}, {24'd0, exp[i]});
    endtask

    initial begin
        logic [DW-1:0] exp4[4];
        @(negedge clk);

        // Passthrough 0..15, 3-cycle latency, 16 consecutive pops
        fifo.delete();
        for (int i = 0; i < 16; i++) fifo.push_back(DW'(i));
        i_ready = 1'b1;
        do_reset(2'b00);
        repeat (22) step();
        check("pt_count", out_q.size(), 16);
        check("pt_pops", pop_c.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < out_q.size()) check("pt_data", {24'd0, out_q[i]}, i);
            if (i < out_q.size() && i < pop_c.size())
                check("pt_lat", out_c[i] - pop_c[i], 3);
            if (i > 0 && i < pop_c.size()) check("pt_contig", pop_c[i] - pop_c[0], i);
        end

        // Gaussian on a constant frame of 100
        fifo.delete();
        for (int i = 0; i < 16; i++) fifo.push_back(8'd100);
        do_reset(2'b01);
        repeat (25) step();
        exp4 = '{8'd100, 8'd100, 8'd100, 8'd100};
        check_outs("gc", exp4);
        if (out_c.size() > 0 && pop_c.size() > 10)
            check("gc_first", out_c[0], pop_c[10] + 3);

        // Gaussian impulse response: 255 at (1,1)
        fifo.delete();
        for (int i = 0; i < 16; i++) fifo.push_back((i == 5) ? 8'd255 : 8'd0);
        do_reset(2'b01);
        repeat (25) step();
        exp4 = '{8'd64, 8'd32, 8'd32, 8'd16};
        check_outs("gi", exp4);

        // Threshold at 50 on the same impulse
        fifo.delete();
        for (int i = 0; i < 16; i++) fifo.push_back((i == 5) ? 8'd255 : 8'd0);
        i_thresh = 8'd50;
        do_reset(2'b10);
        repeat (25) step();
        exp4 = '{8'd255, 8'd0, 8'd0, 8'd0};
        check_outs("th", exp4);

        // Backpressure: ready low for 5 cycles while pixel 3 is on the output
        fifo.delete();
        for (int i = 0; i < 16; i++) fifo.push_back(DW'(i));
        do_reset(2'b00);
        repeat (6) step();
        i_ready = 1'b0;
        repeat (5) begin
            drive();
            check("bp_rd", {31'd0, o_rd}, 32'd0);
            check("bp_valid", {31'd0, o_valid}, 32'd1);
            check("bp_data", {24'd0, o_data}, 32'd3);
            edge_step();
        end
        i_ready = 1'b1;
        repeat (20) step();
        check("bp_count", out_q.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < out_q.size()) check("bp_seq", {24'd0, out_q[i]}, i);

        // Mode change ignored mid-frame, then flush relatches Gaussian
        fifo.delete();
        for (int i = 0; i < 6; i++) fifo.push_back(DW'(i));
        for (int i = 0; i < 16; i++) fifo.push_back(8'd40);
        do_reset(2'b00);
        repeat (3) step();
        i_mode = 2'b01;
        repeat (3) step();
        check("fm_count", out_q.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < out_q.size()) check("fm_pass", {24'd0, out_q[i]}, i);
        i_flush = 1'b1;
        drive();
        check("fm_flush_rd", {31'd0, o_rd}, 32'd0);
        edge_step();
        i_flush = 1'b0;
        clear_logs();
        drive();
        check("fm_drop", {31'd0, o_valid}, 32'd0);
        edge_step();
        repeat (25) step();
        exp4 = '{8'd40, 8'd40, 8'd40, 8'd40};
        check_outs("fm_gauss", exp4);
        if (out_c.size() > 0 && pop_c.size() > 2 * LINE_W + 2)
            check("fm_first", out_c[0], pop_c[2 * LINE_W + 2] + 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
